// File: rtl/medac_sweep_ctrl.sv
// medac_sweep_ctrl
// Calibration sequencer for the MEDAC asynchronous FIFO, running in the FIFO
// write-clock domain. It sweeps all 64 combinations of the two synchronizer
// delay selects {d1,d2}, with d2 as the inner loop. At each point it does the
// following:
//   1. Applies the setting and idles for SETTLE cycles.
//   2. Snapshots the free-running origin-error counter.
//   3. Runs FIFO traffic for WINDOW cycles.
//   4. Keeps the point with the smallest error delta. On a tie the earlier
//      point is kept.
// When the sweep ends (normally or through abort), the best setting is driven
// back onto the selects.
//
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   start, abort           sweep control (start: single-cycle pulse)
//   error_origin_cnt[31:0] free-running FIFO origin-error count
//   delay_sel_d1/d2[2:0]   delay selects to the FIFO
//   traffic_en             gates FIFO winc/rinc/start
//   busy, done             sweep in progress / one-cycle completion pulse
//   best_d1/d2, best_err   best point found so far and its error delta
//
// Optional build macro MEDAC_SWEEP_LOG_EN adds a per-point log:
//   pt_valid, pt_idx[5:0], pt_err[31:0]
//
// States:
//   state  | meaning
//   IDLE   | waiting for start, selects hold best
//   APPLY  | selects driven to current point (1 cycle)
//   SETTLE | traffic off, wait SETTLE cycles
//   BASE   | snapshot error counter (1 cycle)
//   RUN    | traffic on for WINDOW cycles
//   EVAL   | compute delta, update best, advance (1 cycle)
//   DONE   | done pulse, selects switch to best (1 cycle)
module medac_sweep_ctrl #(
  parameter int unsigned WINDOW = 1024,
  parameter int unsigned SETTLE = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic [31:0] error_origin_cnt,
  output logic [2:0]  delay_sel_d1,
  output logic [2:0]  delay_sel_d2,
  output logic        traffic_en,
  output logic        busy,
  output logic        done,
  output logic [2:0]  best_d1,
  output logic [2:0]  best_d2,
  output logic [31:0] best_err
`ifdef MEDAC_SWEEP_LOG_EN
  ,
  output logic        pt_valid,
  output logic [5:0]  pt_idx,
  output logic [31:0] pt_err
`endif
);

  typedef enum logic [2:0] {
    S_IDLE, S_APPLY, S_SETTLE, S_BASE, S_RUN, S_EVAL, S_DONE
  } state_t;

  // Down-counter reload values: the phase ends when the timer reads zero.
  localparam logic [19:0] WIN_LD = 20'(WINDOW - 1);
  localparam logic [19:0] SET_LD = 20'(SETTLE - 1);

  state_t      state_q;
  logic [5:0]  idx_q;
  logic [19:0] tmr_q;
  logic [31:0] base_q;

  logic [31:0] delta_d;
  logic [2:0]  best_d1_d;
  logic [2:0]  best_d2_d;
  logic [31:0] best_err_d;

  // The modular subtraction absorbs a counter wrap inside the window.
  // The strict compare keeps the earlier point on a tie.
  always_comb begin
    delta_d    = error_origin_cnt - base_q;
    best_d1_d  = best_d1;
    best_d2_d  = best_d2;
    best_err_d = best_err;
    if (delta_d < best_err) begin
      best_d1_d  = idx_q[5:3];
      best_d2_d  = idx_q[2:0];
      best_err_d = delta_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      tmr_q        <= '0;
      base_q       <= '0;
      delay_sel_d1 <= '0;
      delay_sel_d2 <= '0;
      traffic_en   <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      best_d1      <= '0;
      best_d2      <= '0;
      best_err     <= '1;
`ifdef MEDAC_SWEEP_LOG_EN
      pt_valid     <= 1'b0;
      pt_idx       <= '0;
      pt_err       <= '0;
`endif
    end else begin
      done <= 1'b0;
`ifdef MEDAC_SWEEP_LOG_EN
      pt_valid <= 1'b0;
`endif
      if (abort && state_q != S_IDLE && state_q != S_DONE) begin
        // The point in flight is dropped, so best reflects completed points only.
        state_q      <= S_DONE;
        done         <= 1'b1;
        busy         <= 1'b0;
        traffic_en   <= 1'b0;
        delay_sel_d1 <= best_d1;
        delay_sel_d2 <= best_d2;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (start) begin
              state_q      <= S_APPLY;
              idx_q        <= '0;
              delay_sel_d1 <= '0;
              delay_sel_d2 <= '0;
              busy         <= 1'b1;
              best_d1      <= '0;
              best_d2      <= '0;
              best_err     <= '1;
            end
          end
          S_APPLY: begin
            state_q <= S_SETTLE;
            tmr_q   <= SET_LD;
          end
          S_SETTLE: begin
            if (tmr_q == '0) state_q <= S_BASE;
            else             tmr_q   <= tmr_q - 20'd1;
          end
          S_BASE: begin
            state_q    <= S_RUN;
            base_q     <= error_origin_cnt;
            traffic_en <= 1'b1;
            tmr_q      <= WIN_LD;
          end
          S_RUN: begin
            if (tmr_q == '0) begin
              state_q    <= S_EVAL;
              traffic_en <= 1'b0;
            end else begin
              tmr_q <= tmr_q - 20'd1;
            end
          end
          S_EVAL: begin
            best_d1  <= best_d1_d;
            best_d2  <= best_d2_d;
            best_err <= best_err_d;
`ifdef MEDAC_SWEEP_LOG_EN
            pt_valid <= 1'b1;
            pt_idx   <= idx_q;
            pt_err   <= delta_d;
`endif
            if (idx_q == 6'd63) begin
              state_q      <= S_DONE;
              done         <= 1'b1;
              busy         <= 1'b0;
              delay_sel_d1 <= best_d1_d;
              delay_sel_d2 <= best_d2_d;
            end else begin
              state_q      <= S_APPLY;
              idx_q        <= idx_q + 6'd1;
              delay_sel_d1 <= (idx_q + 6'd1) >> 3;
              delay_sel_d2 <= (idx_q + 6'd1) & 6'd7;
            end
          end
          S_DONE:  state_q <= S_IDLE;
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_medac_sweep_ctrl.sv
module tb_medac_sweep_ctrl;
  localparam int unsigned W = 8;
  localparam int unsigned S = 2;
  localparam int unsigned P = W + S + 3;

  logic        clk = 1'b0;
  logic        rst, start, abort;
  logic [31:0] error_origin_cnt;
  logic [2:0]  delay_sel_d1, delay_sel_d2, best_d1, best_d2;
  logic        traffic_en, busy, done;
  logic [31:0] best_err;
`ifdef MEDAC_SWEEP_LOG_EN
  logic        pt_valid;
  logic [5:0]  pt_idx;
  logic [31:0] pt_err;
`endif

  int checks = 0;
  int errors = 0;

  // Error model: each RUN cycle adds pc[point]; the first RUN cycle of a
  // point also adds lump[point]. Expected delta = W*pc + lump (mod 2^32).
  int unsigned pc[64];
  logic [31:0] lump[64];
  logic [31:0] load_val = '0;
  int          load_seq = 0;
  int unsigned te_total = 0;
  int unsigned log_pulses = 0;

  medac_sweep_ctrl #(.WINDOW(W), .SETTLE(S)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .error_origin_cnt(error_origin_cnt),
    .delay_sel_d1(delay_sel_d1), .delay_sel_d2(delay_sel_d2),
    .traffic_en(traffic_en), .busy(busy), .done(done),
    .best_d1(best_d1), .best_d2(best_d2), .best_err(best_err)
`ifdef MEDAC_SWEEP_LOG_EN
    , .pt_valid(pt_valid), .pt_idx(pt_idx), .pt_err(pt_err)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  logic [31:0] cnt_m = '0;
  bit          first_run = 1'b1;
  int          seen_seq = 0;
  always @(negedge clk) begin
    if (load_seq != seen_seq) begin
      seen_seq = load_seq;
      cnt_m    = load_val;
    end
    if (traffic_en === 1'b1) begin
      te_total++;
      cnt_m = cnt_m + pc[{delay_sel_d1, delay_sel_d2}];
      if (first_run) cnt_m = cnt_m + lump[{delay_sel_d1, delay_sel_d2}];
      first_run = 1'b0;
    end else begin
      first_run = 1'b1;
    end
    error_origin_cnt = cnt_m;
  end

`ifdef MEDAC_SWEEP_LOG_EN
  int   log_exp = 0;
  logic busy_p = 1'b0;
  always @(negedge clk) begin
    if (busy === 1'b1 && busy_p !== 1'b1) log_exp = 0;
    busy_p = busy;
    if (pt_valid === 1'b1) begin
      log_pulses++;
      chk("log_idx", 32'(pt_idx), 32'(log_exp));
      chk("log_err", pt_err, W * pc[pt_idx] + lump[pt_idx]);
      log_exp++;
    end
  end
`endif

  // Reference: best over the first n completed points, earliest wins on ties.
  function automatic void ref_best(input int n, output logic [5:0] bi, output logic [31:0] be);
    logic [31:0] d;
    be = '1;
    bi = '0;
    for (int i = 0; i < n; i++) begin
      d = W * pc[i] + lump[i];
      if (d < be) begin
        be = d;
        bi = 6'(i);
      end
    end
  endfunction

  task automatic set_tables(input int unsigned binc, input int za, input int zb,
                            input int li, input logic [31:0] lv, input logic [31:0] init);
    for (int i = 0; i < 64; i++) begin
      pc[i]   = binc;
      lump[i] = '0;
    end
    if (za >= 0) pc[za] = 0;
    if (zb >= 0) pc[zb] = 0;
    if (li >= 0) lump[li] = lv;
    load_val = init;
    load_seq++;
    @(negedge clk);
    @(negedge clk);
  endtask

  // Leaves the bench at the negedge after the edge that sampled start.
  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_sweep(input string tag, input logic [2:0] ed1, input logic [2:0] ed2,
                           input logic [31:0] eerr);
    int          n;
    int unsigned te0, lp0;
    te0 = te_total;
    lp0 = log_pulses;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    n = 1;
    @(negedge clk);
    start = 1'b0;
    chk({tag, "_busy_up"}, 32'(busy), 32'd1);
    while (done !== 1'b1 && n < int'(64 * P + 50)) begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    chk({tag, "_latency"}, 32'(n), 64 * P + 1);
    chk({tag, "_best_d1"}, 32'(best_d1), 32'(ed1));
    chk({tag, "_best_d2"}, 32'(best_d2), 32'(ed2));
    chk({tag, "_best_err"}, best_err, eerr);
    chk({tag, "_busy_dn"}, 32'(busy), 32'd0);
    @(negedge clk);
    chk({tag, "_done_1cyc"}, 32'(done), 32'd0);
    chk({tag, "_sel_d1"}, 32'(delay_sel_d1), 32'(ed1));
    chk({tag, "_sel_d2"}, 32'(delay_sel_d2), 32'(ed2));
    chk({tag, "_traffic"}, te_total - te0, 64 * W);
`ifdef MEDAC_SWEEP_LOG_EN
    chk({tag, "_log_cnt"}, log_pulses - lp0, 32'd64);
`endif
  endtask

  typedef struct {
    int unsigned binc;
    int          za;
    int          zb;
    int          li;
    logic [31:0] lv;
    logic [31:0] init;
    logic [2:0]  ed1;
    logic [2:0]  ed2;
    logic [31:0] eerr;
  } vec_t;

  vec_t        vecs[5];
  logic [5:0]  rbi;
  logic [31:0] rbe;

  initial begin
    vecs[0] = '{0, -1, -1, -1, 32'h0,         32'h0000_1234,        3'd0, 3'd0, 32'd0};
    vecs[1] = '{1, 43, -1, -1, 32'h0,         32'h0,                3'd5, 3'd3, 32'd0};
    vecs[2] = '{1, 10, 40, -1, 32'h0,         32'h0,                3'd1, 3'd2, 32'd0};
    vecs[3] = '{1, 20, -1, 20, 32'd3,         32'hFFFF_FFFE - 160,  3'd2, 3'd4, 32'd3};
    vecs[4] = '{2, -1, -1, 63, 32'hFFFF_FFF0, 32'h0,                3'd7, 3'd7, 32'd0};

    rst   = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    for (int i = 0; i < 64; i++) begin
      pc[i]   = 0;
      lump[i] = '0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_sel_d1", 32'(delay_sel_d1), 32'd0);
    chk("rst_sel_d2", 32'(delay_sel_d2), 32'd0);
    chk("rst_traffic", 32'(traffic_en), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_best_d1", 32'(best_d1), 32'd0);
    chk("rst_best_d2", 32'(best_d2), 32'd0);
    chk("rst_best_err", best_err, 32'hFFFF_FFFF);
`ifdef MEDAC_SWEEP_LOG_EN
    chk("rst_pt_valid", 32'(pt_valid), 32'd0);
`endif
    rst = 1'b0;

    for (int v = 0; v < 5; v++) begin
      set_tables(vecs[v].binc, vecs[v].za, vecs[v].zb, vecs[v].li, vecs[v].lv, vecs[v].init);
      run_sweep($sformatf("vec%0d", v), vecs[v].ed1, vecs[v].ed2, vecs[v].eerr);
    end

    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 64; i++) begin
        pc[i]   = $urandom_range(0, 3);
        lump[i] = 32'($urandom_range(0, 20));
      end
      load_val = $urandom;
      load_seq++;
      @(negedge clk);
      @(negedge clk);
      ref_best(64, rbi, rbe);
      run_sweep($sformatf("rnd%0d", r), rbi[5:3], rbi[2:0], rbe);
    end

    // Abort after three completed points (deltas 5, 2, 4); a start pulse
    // during the sweep must not restart it.
    set_tables(0, -1, -1, 0, 32'd5, 32'h0);
    lump[1] = 32'd2;
    lump[2] = 32'd4;
    pulse_start();
    repeat (P + 8) @(posedge clk);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (2 * P - 3) @(posedge clk);
    @(negedge clk);
    chk("abort_pre_traffic", 32'(traffic_en), 32'd1);
    abort = 1'b1;
    @(posedge clk);
    @(negedge clk);
    abort = 1'b0;
    chk("abort_done", 32'(done), 32'd1);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_traffic", 32'(traffic_en), 32'd0);
    chk("abort_best_d1", 32'(best_d1), 32'd0);
    chk("abort_best_d2", 32'(best_d2), 32'd1);
    chk("abort_best_err", best_err, 32'd2);
    chk("abort_sel_d2", 32'(delay_sel_d2), 32'd1);
    @(negedge clk);
    chk("abort_done_1cyc", 32'(done), 32'd0);
    chk("abort_hold_err", best_err, 32'd2);

    // Start and abort together in IDLE: start wins; then abort before any point completes.
    @(negedge clk);
    start = 1'b1;
    abort = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    chk("startabort_busy", 32'(busy), 32'd1);
    chk("startabort_done", 32'(done), 32'd0);
    repeat (4) @(posedge clk);
    @(negedge clk);
    abort = 1'b1;
    @(posedge clk);
    @(negedge clk);
    abort = 1'b0;
    chk("abort0_done", 32'(done), 32'd1);
    chk("abort0_best_err", best_err, 32'hFFFF_FFFF);
    chk("abort0_best_d2", 32'(best_d2), 32'd0);

    // Reset during RUN of point 2 after two points of delta 8.
    set_tables(1, -1, -1, -1, 32'h0, 32'h0);
    pulse_start();
    repeat (2 * P + 6) @(posedge clk);
    @(negedge clk);
    chk("rstmid_pre_traffic", 32'(traffic_en), 32'd1);
    chk("rstmid_pre_err", best_err, 32'd8);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rstmid_traffic", 32'(traffic_en), 32'd0);
    chk("rstmid_busy", 32'(busy), 32'd0);
    chk("rstmid_sel_d1", 32'(delay_sel_d1), 32'd0);
    chk("rstmid_sel_d2", 32'(delay_sel_d2), 32'd0);
    chk("rstmid_best_err", best_err, 32'hFFFF_FFFF);
    repeat (3) @(negedge clk);
    chk("rstmid_idle", 32'(busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
